// File: rtl/crc8_serial_lfsr.sv
// Serial CRC-8 generator: absorbs a bit-serial message into an 8-bit LFSR while ACTIVE
// is high, then shifts the CRC out LSB first with Valid high for CRC_WD cycles.
module crc8_serial_lfsr #(
    parameter logic [7:0] SEED   = 8'hD8,
    parameter logic [7:0] TAPS   = 8'b0100_0100,
    parameter int         CRC_WD = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic DATA,
    input  logic ACTIVE,
    output logic CRC,
    output logic Valid
);

    localparam logic [3:0] CNT_END  = 4'(CRC_WD);
    localparam logic [3:0] CNT_LAST = 4'(CRC_WD - 1);

    logic [7:0] lfsr;
    logic [3:0] cnt;
    logic       pend;

    logic       fb;
    logic [7:0] lfsr_absorb;
    logic       emit_en;
    logic       last_bit;

    // TAPS[7] has no effect: the top bit always takes the feedback directly.
    always_comb begin
        fb          = DATA ^ lfsr[0];
        lfsr_absorb = {fb, lfsr[7:1] ^ (TAPS[6:0] & {7{fb}})};
        emit_en     = !ACTIVE && pend && (cnt < CNT_END);
        last_bit    = (cnt == CNT_LAST);
    end

    // NOTE: state registers use non-blocking assignments so every bit updates from the
    // pre-edge values; blocking here would chain the LFSR shift within one edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr  <= SEED;
            cnt   <= '0;
            pend  <= 1'b0;
            CRC   <= 1'b0;
            Valid <= 1'b0;
        end else if (ACTIVE) begin
            // A bit arriving mid-emission aborts it and restarts the count.
            lfsr  <= lfsr_absorb;
            pend  <= 1'b1;
            cnt   <= '0;
            CRC   <= 1'b0;
            Valid <= 1'b0;
        end else if (emit_en) begin
            CRC   <= lfsr[0];
            Valid <= 1'b1;
            lfsr  <= {1'b0, lfsr[7:1]};
            cnt   <= cnt + 4'd1;
            if (last_bit) begin
                pend <= 1'b0;
            end
        end else begin
            CRC   <= 1'b0;
            Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc8_serial_lfsr.sv
// Directed bench for crc8_serial_lfsr: table of message/CRC pairs plus hand-written
// sequences for idle, reset mid-emission, abort-by-ACTIVE and back-to-back messages.
module tb_crc8_serial_lfsr;

    logic CLK;
    logic RST;
    logic DATA;
    logic ACTIVE;
    logic CRC;
    logic Valid;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] msg;
        logic [7:0] crc;
    } vec_t;

    vec_t vecs[11];

    crc8_serial_lfsr dut (
        .CLK   (CLK),
        .RST   (RST),
        .DATA  (DATA),
        .ACTIVE(ACTIVE),
        .CRC   (CRC),
        .Valid (Valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST    = 1'b0;
        ACTIVE = 1'b0;
        DATA   = 1'b0;
        #1;
        check("reset_outputs", {30'b0, Valid, CRC}, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic send_msg(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            ACTIVE = 1'b1;
            DATA   = m[i];
        end
        @(negedge CLK);
        ACTIVE = 1'b0;
        DATA   = 1'b0;
    endtask

    // Samples a fixed window of negedges after ACTIVE falls, assembling CRC bits LSB first.
    task automatic collect(output logic [7:0] crc_out, output int n_valid,
                           output int first_idx, output int last_idx);
        crc_out   = '0;
        n_valid   = 0;
        first_idx = -1;
        last_idx  = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (Valid === 1'b1) begin
                if (first_idx < 0) first_idx = c;
                last_idx = c;
                if (n_valid < 8) crc_out[n_valid] = CRC;
                n_valid++;
            end
        end
    endtask

    task automatic check_burst(input string name, input logic [7:0] expected);
        logic [7:0] got;
        int         nv;
        int         fi;
        int         li;
        collect(got, nv, fi, li);
        check({name, "_crc"}, {24'b0, got}, {24'b0, expected});
        check({name, "_valid_count"}, nv, 8);
        check({name, "_first_valid_cycle"}, fi, 0);
        check({name, "_last_valid_cycle"}, li, 7);
    endtask

    initial begin
        logic [7:0] got;
        int         nv;
        int         fi;
        int         li;
        logic [7:0] crc_00;

        // CRC(m) = 0x14 ^ XOR of per-bit contributions {AB,DF,37,6E,DC,31,62,C4}.
        vecs[0]  = '{msg: 8'h00, crc: 8'h14};
        vecs[1]  = '{msg: 8'hFF, crc: 8'h72};
        vecs[2]  = '{msg: 8'h01, crc: 8'hBF};
        vecs[3]  = '{msg: 8'h80, crc: 8'hD0};
        vecs[4]  = '{msg: 8'hA5, crc: 8'h7D};
        vecs[5]  = '{msg: 8'h5A, crc: 8'h1B};
        vecs[6]  = '{msg: 8'h3C, crc: 8'hA0};
        vecs[7]  = '{msg: 8'hC3, crc: 8'hC6};
        vecs[8]  = '{msg: 8'h12, crc: 8'h17};
        vecs[9]  = '{msg: 8'h7E, crc: 8'h1D};
        vecs[10] = '{msg: 8'h81, crc: 8'h7B};
        crc_00   = 8'h14;

        RST    = 1'b0;
        ACTIVE = 1'b0;
        DATA   = 1'b0;
        #2;
        check("por_outputs", {30'b0, Valid, CRC}, 32'h0);

        // Idle after reset: no message absorbed, so nothing is ever emitted.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            check("idle_outputs", {30'b0, Valid, CRC}, 32'h0);
        end

        foreach (vecs[i]) begin
            do_reset();
            send_msg(vecs[i].msg);
            check_burst($sformatf("vec%0d_msg%02h", i, vecs[i].msg), vecs[i].crc);
        end

        // Reset asserted asynchronously while the third CRC bit (a 1) is on the output.
        do_reset();
        send_msg(8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("midreset_valid_before", {31'b0, Valid}, 32'h1);
            check("midreset_crc_before", {31'b0, CRC}, {31'b0, crc_00[c]});
        end
        #2;
        RST = 1'b0;
        #1;
        check("midreset_outputs_async", {30'b0, Valid, CRC}, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        collect(got, nv, fi, li);
        check("midreset_no_valid_after", nv, 0);

        // ACTIVE re-asserted for one bit (DATA=1) after three emitted bits.
        do_reset();
        send_msg(8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("abort_valid_before", {31'b0, Valid}, 32'h1);
        end
        ACTIVE = 1'b1;
        DATA   = 1'b1;
        @(negedge CLK);
        check("abort_valid_drops", {31'b0, Valid}, 32'h0);
        ACTIVE = 1'b0;
        DATA   = 1'b0;
        check_burst("abort_reemit", 8'hC5);

        // Back-to-back messages: later messages start from the emptied LFSR.
        do_reset();
        send_msg(8'h00);
        check_burst("b2b_first", 8'h14);
        send_msg(8'h00);
        check_burst("b2b_second", 8'h00);
        send_msg(8'hFF);
        check_burst("b2b_third", 8'h66);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
